// File: rtl/word_sched_pkg.sv
// Shared state encoding and display word codes for word_scheduler.
// WORD_SCHED_BLANK_GAP_EN adds the GAP state to the enum.
package word_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1
`ifdef WORD_SCHED_BLANK_GAP_EN
    , ST_GAP = 2'd2
`endif
  } state_e;

  localparam logic [1:0] WORD_PLAY  = 2'd0;
  localparam logic [1:0] WORD_LIVE  = 2'd1;
  localparam logic [1:0] WORD_DEAD  = 2'd2;
  localparam logic [1:0] WORD_BLANK = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles; clr_i restarts the count.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_scheduler.sv
// Round-robin word display scheduler: shows each granted word for HOLD_TICKS ticks.
// Define WORD_SCHED_BLANK_GAP_EN to insert GAP_TICKS blank ticks after every word.
module word_scheduler
  import word_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [1:0]         word_sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done
);

  localparam int unsigned  PW     = $clog2(NUM_REQ);
  localparam logic [PW:0]  NREQ_W = (PW + 1)'(NUM_REQ);
`ifdef WORD_SCHED_BLANK_GAP_EN
  localparam int unsigned  TERM   = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
`else
  localparam int unsigned  TERM   = HOLD_TICKS;
`endif
  localparam int unsigned  TW        = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
`ifdef WORD_SCHED_BLANK_GAP_EN
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
`endif

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   cur_q, cur_d;
  logic [TW-1:0]   tk_q, tk_d;
  logic [TW-1:0]   phase_last;
  logic            tick, phase_end, tick_clr, show;
  logic            found, take;
  logic [PW-1:0]   win;
  logic [PW:0]     idx, nxt;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .en_i   (busy),
    .tick_o (tick)
  );

  // Round-robin search from ptr_q upward with wrap; first asserted bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW + 1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    nxt = {1'b0, win} + (PW + 1)'(1);
    if (nxt == NREQ_W) nxt = '0;
  end

  always_comb begin
    phase_last = HOLD_LAST;
`ifdef WORD_SCHED_BLANK_GAP_EN
    if (state_q == ST_GAP) phase_last = GAP_LAST;
`endif
  end

  assign phase_end = tick && (tk_q == phase_last);
  // Counters sit cleared in IDLE, so every phase starts from zero.
  assign tick_clr  = (state_q == ST_IDLE) || phase_end;

  always_comb begin
    tk_d = tk_q;
    if (tick_clr) begin
      tk_d = '0;
    end else if (tick) begin
      tk_d = tk_q + TW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: take = found;
      ST_SHOW: begin
        if (phase_end) begin
`ifdef WORD_SCHED_BLANK_GAP_EN
          state_d = ST_GAP;
`else
          take = found;
          if (!found) state_d = ST_IDLE;
`endif
        end
      end
`ifdef WORD_SCHED_BLANK_GAP_EN
      ST_GAP: begin
        if (phase_end) begin
          take = found;
          if (!found) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_SHOW;
      cur_d   = win;
      ptr_d   = nxt[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      tk_q    <= tk_d;
    end
  end

  assign show     = (state_q == ST_SHOW);
  assign busy     = (state_q != ST_IDLE);
  assign done     = show && phase_end;
  assign word_sel = show ? (WORD_PLAY + 2'(cur_q)) : WORD_BLANK;
  assign grant    = show ? (NUM_REQ'(1) << cur_q) : '0;

endmodule

// File: tb/tb_word_scheduler.sv
// Directed scoreboard bench for word_scheduler (TICK_DIV=4, HOLD_TICKS=2, GAP_TICKS=1).
// Expected blank spacing follows WORD_SCHED_BLANK_GAP_EN.
module tb_word_scheduler;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DIV  = 4;
  localparam int unsigned HOLD = 2;
  localparam int unsigned GAPT = 1;
  localparam int SHOW_CYC = HOLD * DIV;
`ifdef WORD_SCHED_BLANK_GAP_EN
  localparam int   GAP_CYC   = GAPT * DIV;
  localparam logic POST_BUSY = 1'b1;
`else
  localparam int   GAP_CYC   = 0;
  localparam logic POST_BUSY = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic [1:0]      word_sel;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;
  logic [NREQ-1:0] exp_q[$];

  always #5 clk = ~clk;

  word_scheduler #(
    .NUM_REQ    (NREQ),
    .TICK_DIV   (DIV),
    .HOLD_TICKS (HOLD),
    .GAP_TICKS  (GAPT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .word_sel (word_sel),
    .grant    (grant),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input logic [NREQ-1:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Counts blank cycles until a grant appears, bounded by maxc.
  task automatic wait_grant(input string tag, input int maxc, input int exp_blanks);
    int blanks;
    blanks = 0;
    while (grant === '0 && blanks < maxc) begin
      @(negedge clk);
      blanks++;
    end
    chk({tag, "_blanks"}, blanks, exp_blanks);
  endtask

  // Entered on SHOW cycle 1; leaves on the cycle after the done pulse.
  task automatic show_check(input string tag);
    logic [NREQ-1:0] e;
    int   len;
    logic stable;
    chk({tag, "_sb_avail"}, exp_q.size() > 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_grant"}, grant, e);
    chk({tag, "_word"}, word_sel, code_of(e));
    chk({tag, "_busy"}, busy, 1);
    len    = 1;
    stable = 1'b1;
    while (done !== 1'b1 && len < 3 * SHOW_CYC) begin
      @(negedge clk);
      len++;
      if (grant !== e) stable = 1'b0;
    end
    chk({tag, "_len"}, len, SHOW_CYC);
    chk({tag, "_stable"}, stable, 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_word", word_sel, 3);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_word", word_sel, 3);
    chk("idle_busy", busy, 0);

    // Single-cycle request; dropping req must not shorten SHOW
    req = 3'b010;
    exp_q.push_back(3'b010);
    @(negedge clk);
    req = '0;
    wait_grant("one", 3, 0);
    show_check("one");
    chk("one_post_busy", busy, POST_BUSY);
    chk("one_post_word", word_sel, 3);
    chk("one_post_grant", grant, 0);
    repeat (GAP_CYC + 2) @(negedge clk);
    chk("one_settle_busy", busy, 0);

    // Pointer parked at 1, then 101 held: 100 before 001
    pulse_reset();
    req = 3'b001;
    exp_q.push_back(3'b001);
    @(negedge clk);
    req = '0;
    wait_grant("ptr1", 3, 0);
    show_check("ptr1");
    repeat (GAP_CYC + 2) @(negedge clk);
    req = 3'b101;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    @(negedge clk);
    wait_grant("rr_a", 3, 0);
    show_check("rr_a");
    wait_grant("rr_b", GAP_CYC + 3, GAP_CYC);
    req = '0;
    show_check("rr_b");
    repeat (GAP_CYC + 2) @(negedge clk);
    chk("rr_settle_busy", busy, 0);

    // All requesting after reset: 001,010,100,001
    pulse_reset();
    req = 3'b111;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    @(negedge clk);
    wait_grant("all0", 3, 0);
    show_check("all0");
    wait_grant("all1", GAP_CYC + 3, GAP_CYC);
    show_check("all1");
    wait_grant("all2", GAP_CYC + 3, GAP_CYC);
    show_check("all2");
    wait_grant("all3", GAP_CYC + 3, GAP_CYC);
    req = '0;
    show_check("all3");
    repeat (GAP_CYC + 2) @(negedge clk);
    chk("all_settle_busy", busy, 0);

    // Single requester held: re-granted every arbitration
    req = 3'b100;
    for (int i = 0; i < 3; i++) exp_q.push_back(3'b100);
    @(negedge clk);
    wait_grant("solo0", 3, 0);
    show_check("solo0");
    wait_grant("solo1", GAP_CYC + 3, GAP_CYC);
    show_check("solo1");
    wait_grant("solo2", GAP_CYC + 3, GAP_CYC);
    req = '0;
    show_check("solo2");
    repeat (GAP_CYC + 2) @(negedge clk);
    chk("solo_settle_busy", busy, 0);

    // Reset mid-SHOW (cycle 3): immediate abort, no done
    req = 3'b010;
    @(negedge clk);
    req = '0;
    wait_grant("abort", 3, 0);
    chk("abort_grant", grant, 3'b010);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_grant_rst", grant, 0);
    chk("abort_word_rst", word_sel, 3);
    chk("abort_busy_rst", busy, 0);
    chk("abort_done_rst", done, 0);
    @(negedge clk);
    chk("abort_done_hold", done, 0);

    // First edge after release grants, pointer back at 0
    rst_n = 1'b1;
    req   = 3'b111;
    exp_q.push_back(3'b001);
    @(negedge clk);
    wait_grant("post_rst", 0, 0);
    req = '0;
    show_check("post_rst");
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
